// File: rtl/multiplier_controller_taint_track.sv
// Sequencing FSM for the taint-tracked shift-add multiplier: one LOAD cycle, then a fixed
// EXAM/SHIFT pair per multiplier bit, then a one-cycle DONE pulse. Strobes carry control taint.
module multiplier_controller_taint_track #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic             multiplierReg_t,
  output logic             mdld,
  output logic             mrld,
  output logic             rsclear,
  output logic             mdld_t,
  output logic             mrld_t,
  output logic             rsclear_t,
  output logic             rsload,
  output logic             rsload_t,
  output logic             rsshr,
  output logic             rsshr_t,
  output logic             busy,
  output logic             done,
  output logic             done_t,
  output logic [2:0]       dbg_state_o,
  output logic             dbg_ctl_t_o
);

  localparam int SELW = $clog2(WIDTH);
  localparam int IDXW = SELW + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EXAM  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  logic [IDXW-1:0] idx_q;
  logic            ctl_t_q;

  // Handshake: start is a level request with no ready; it is sampled only in IDLE and
  // dropped in every other state, so a request arriving while busy is simply lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ctl_t_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            ctl_t_q <= start_t;
          end
        end
        S_LOAD:  state_q <= S_EXAM;
        S_EXAM:  state_q <= S_SHIFT;
        S_SHIFT: begin
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_EXAM;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic in_load, in_exam, in_shift, in_done;

  assign in_load  = (state_q == S_LOAD);
  assign in_exam  = (state_q == S_EXAM);
  assign in_shift = (state_q == S_SHIFT);
  assign in_done  = (state_q == S_DONE);

  assign mdld    = in_load;
  assign mrld    = in_load;
  assign rsclear = in_load;
  // EXAM and SHIFT are distinct states, so rsload and rsshr can never overlap.
  assign rsload  = in_exam && multiplierReg[idx_q[SELW-1:0]];
  assign rsshr   = in_shift;
  assign done    = in_done;
  assign busy    = (state_q != S_IDLE);

  assign mdld_t    = in_load && ctl_t_q;
  assign mrld_t    = in_load && ctl_t_q;
  assign rsclear_t = in_load && ctl_t_q;
  // Only the add decision reads multiplier data; schedule timing never does.
  assign rsload_t  = in_exam && (ctl_t_q || multiplierReg_t);
  assign rsshr_t   = in_shift && ctl_t_q;
  assign done_t    = in_done && ctl_t_q;

  assign dbg_state_o = state_q;
  assign dbg_ctl_t_o = ctl_t_q;

endmodule

// File: tb/tb_multiplier_controller_taint_track.sv
// Bench for the multiplier controller: drives a small shift-add datapath, compares every
// cycle against a cycle-offset model, and pins the model with hand-computed results.
module tb_multiplier_controller_taint_track;

  localparam int W    = 4;
  localparam int LAST = 2 * W + 2;

  logic         clk = 1'b0;
  logic         reset, start, start_t, mr_t;
  logic [W-1:0] md_in, mr_in;
  logic [W-1:0] md_reg, mr_reg;
  logic [2*W:0] sum;
  logic mdld, mrld, rsclear, mdld_t, mrld_t, rsclear_t, rsload, rsload_t;
  logic rsshr, rsshr_t, busy, done, done_t, dbg_ctl_t;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  multiplier_controller_taint_track #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_t(start_t),
    .multiplierReg(mr_reg), .multiplierReg_t(mr_t),
    .mdld(mdld), .mrld(mrld), .rsclear(rsclear),
    .mdld_t(mdld_t), .mrld_t(mrld_t), .rsclear_t(rsclear_t),
    .rsload(rsload), .rsload_t(rsload_t), .rsshr(rsshr), .rsshr_t(rsshr_t),
    .busy(busy), .done(done), .done_t(done_t),
    .dbg_state_o(dbg_state), .dbg_ctl_t_o(dbg_ctl_t)
  );

  // Datapath: running sum adds the multiplicand into the upper half, then shifts right.
  always @(posedge clk) begin
    if (mdld) md_reg <= md_in;
    if (mrld) mr_reg <= mr_in;
    if (rsclear)     sum <= '0;
    else if (rsshr)  sum <= sum >> 1;
    else if (rsload) sum <= sum + ({{(W+1){1'b0}}, md_reg} << W);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since the accepted start (0 = idle).
  int           m_t   = 0;
  logic         m_ctl = 1'b0;
  logic [W-1:0] m_op  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_t   = 0;
      m_ctl = 1'b0;
    end else if (m_t == 0) begin
      if (start) begin
        m_t   = 1;
        m_ctl = start_t;
        m_op  = mr_in;
      end
    end else if (m_t == LAST) begin
      m_t = 0;
    end else begin
      m_t = m_t + 1;
    end
  end

  always @(negedge clk) begin
    logic ld, ex, sh, dn, bitv;
    logic [13:0] act_v, exp_v;
    if (chk_en) begin
      ld   = (m_t == 1);
      ex   = (m_t >= 2) && (m_t <= 2 * W + 1) && (m_t % 2 == 0);
      sh   = (m_t >= 3) && (m_t <= 2 * W + 1) && (m_t % 2 == 1);
      dn   = (m_t == LAST);
      bitv = ex ? m_op[(m_t - 2) / 2] : 1'b0;
      exp_v = {m_t != 0, ld, ld, ld, bitv, sh, dn,
               ld && m_ctl, ld && m_ctl, ld && m_ctl, ex && (m_ctl || mr_t),
               sh && m_ctl, dn && m_ctl, m_ctl};
      act_v = {busy, mdld, mrld, rsclear, rsload, rsshr, done,
               mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t, done_t, dbg_ctl_t};
      check("outputs", 64'(act_v), 64'(exp_v));
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("drain_idle", 64'(busy), 64'd0);
  endtask

  // Start one multiply with its start in cycle 0; observe through done (or second LOAD).
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic st,
                          input logic rt, input logic hold,
                          output int done_cyc, output int n_add, output int n_shr,
                          output int n_rlt, output int load2, output logic [2*W-1:0] prod,
                          output logic dt);
    @(negedge clk);
    md_in = a; mr_in = b; start = 1'b1; start_t = st; mr_t = rt;
    done_cyc = -1; n_add = 0; n_shr = 0; n_rlt = 0; load2 = -1; prod = '0; dt = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (mdld && c > 1 && load2 < 0) load2 = c;
      if (rsload) n_add++;
      if (rsshr) n_shr++;
      if (rsload_t) n_rlt++;
      if (done && done_cyc < 0) begin
        done_cyc = c;
        prod     = sum[2*W-1:0];
        dt       = done_t;
      end
      if (!hold && done_cyc > 0) break;
      if (hold && load2 > 0) break;
    end
    start = 1'b0; mr_t = 1'b0;
    check("done_seen", 64'(done_cyc > 0), 64'd1);
    drain();
  endtask

  task automatic abort_run(input logic [W-1:0] a, input logic [W-1:0] b, input int rc);
    @(negedge clk);
    md_in = a; mr_in = b; start = 1'b1; start_t = 1'b1;
    for (int c = 1; c <= rc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == rc) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ctl_t", 64'(dbg_ctl_t), 64'd0);
  endtask

  initial begin
    int dc, na, ns, nr, l2;
    logic [2*W-1:0] p;
    logic dt;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; start_t = 1'b0; mr_t = 1'b0; md_in = '0; mr_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_strobes", 64'({mdld, rsload, rsshr, done, done_t}), 64'd0);
    reset = 1'b0;

    run_mult(4'd3, 4'd5, 1'b0, 1'b0, 1'b0, dc, na, ns, nr, l2, p, dt);
    check("basic_done_cyc", 64'(dc), 64'd10);
    check("basic_product", 64'(p), 64'd15);
    check("basic_adds", 64'(na), 64'd2);
    check("basic_shifts", 64'(ns), 64'd4);
    check("basic_done_t", 64'(dt), 64'd0);

    run_mult(4'd15, 4'd15, 1'b0, 1'b0, 1'b0, dc, na, ns, nr, l2, p, dt);
    check("max_product", 64'(p), 64'd225);
    check("max_adds", 64'(na), 64'd4);
    run_mult(4'd0, 4'd9, 1'b0, 1'b0, 1'b0, dc, na, ns, nr, l2, p, dt);
    check("zero_product", 64'(p), 64'd0);
    check("zero_done_cyc", 64'(dc), 64'd10);

    run_mult(4'd5, 4'd6, 1'b1, 1'b0, 1'b0, dc, na, ns, nr, l2, p, dt);
    check("taint_done_t", 64'(dt), 64'd1);
    check("taint_product", 64'(p), 64'd30);
    run_mult(4'd5, 4'd6, 1'b0, 1'b1, 1'b0, dc, na, ns, nr, l2, p, dt);
    check("mrt_done_t", 64'(dt), 64'd0);
    check("mrt_rsload_t_cnt", 64'(nr), 64'd4);

    run_mult(4'd2, 4'd3, 1'b0, 1'b0, 1'b1, dc, na, ns, nr, l2, p, dt);
    check("hold_done_cyc", 64'(dc), 64'd10);
    check("hold_second_load", 64'(l2), 64'd12);
    check("hold_product", 64'(p), 64'd6);

    abort_run(4'd9, 4'd11, 5);
    run_mult(4'd2, 4'd7, 1'b0, 1'b0, 1'b0, dc, na, ns, nr, l2, p, dt);
    check("after_abort_product", 64'(p), 64'd14);

    @(negedge clk);
    reset = 1'b1; start = 1'b1; start_t = 1'b1;
    @(negedge clk);
    check("collide_mdld", 64'(mdld), 64'd0);
    check("collide_busy", 64'(busy), 64'd0);
    reset = 1'b0; start = 1'b0; start_t = 1'b0;
    @(negedge clk);
    check("collide_stay_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 4) == 0) begin
        abort_run(ra, rb, $urandom_range(1, 2 * W + 2));
      end else begin
        run_mult(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), dc, na, ns, nr, l2, p, dt);
        check("rand_product", 64'(p), 64'(ra * rb));
        check("rand_done_cyc", 64'(dc), 64'(LAST));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multiplier_controller_taint_track.md
# multiplier_controller_taint_track

Sequencing FSM for the 1-bit taint-tracked sequential multiplier datapath. It accepts a start request, drives the datapath's load, clear, add and shift strobes through a fixed shift-add schedule, and signals completion. Every strobe and the done flag carry a 1-bit taint output, so the datapath's taint registers see control-flow taint. Schedule length is data-independent: every multiplier bit costs exactly two cycles.

## Interface
- WIDTH, 1024: operand width; must match the datapath instance.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- start_t  in  1  taint of start.
- multiplierReg  in  WIDTH  datapath multiplier register, read bit-by-bit.
- multiplierReg_t  in  1  taint of multiplierReg.
- mdld, mrld, rsclear  out  1 each  load multiplicand, load multiplier, clear running sum.
- mdld_t, mrld_t, rsclear_t  out  1 each  taints of those three strobes.
- rsload  out  1  add multiplicandReg into runningSumReg.
- rsload_t  out  1  taint of rsload.
- rsshr  out  1  shift runningSumReg right by one.
- rsshr_t  out  1  taint of rsshr.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; product valid on the datapath.
- done_t  out  1  taint of done.

## Operation
- States: IDLE, LOAD, EXAM, SHIFT, DONE. State, bit counter `idx` ($clog2(WIDTH)+1 bits) and taint flag `ctl_t` are registered.
- IDLE: all strobes are 0. If start=1, go to LOAD, set `ctl_t <= start_t`, and set `idx <= 0`.
- LOAD: assert mdld, mrld and rsclear together for exactly one cycle, then go to EXAM.
- EXAM: assert `rsload = multiplierReg[idx]`.
  - Always go to SHIFT, even when the bit is 0 (constant-time schedule).
  - Never assert rsload and rsshr in the same cycle; the datapath gives rsshr priority.
- SHIFT: assert rsshr.
  - If idx == WIDTH-1, go to DONE.
  - Otherwise increment idx and go to EXAM.
- DONE: done=1 for one cycle, then go to IDLE. start is ignored here.
- start is ignored in every non-IDLE state; there is no queuing.
- Taint rules (all combinational from state, `ctl_t` and multiplierReg_t):
  - mdld_t, mrld_t and rsclear_t each equal `(state==LOAD) && ctl_t`.
  - rsload_t equals `(state==EXAM) && (ctl_t || multiplierReg_t)`. The add decision depends on multiplier data.
  - rsshr_t equals `(state==SHIFT) && ctl_t`.
  - done_t equals `(state==DONE) && ctl_t`. Timing is data-independent, so multiplierReg_t does not taint done.
- `ctl_t` holds its value until the next accepted start or a reset.
- Result: after WIDTH EXAM/SHIFT pairs, datapath product[2*WIDTH-1:0] = multiplicand × multiplier (unsigned).

## Timing
- Reset (synchronous): on the next edge state=IDLE, idx=0, ctl_t=0. All outputs are 0 in the following cycle.
- Reset mid-operation aborts the operation. Datapath register contents are not cleared by this block.
- Reset has priority over start in the same cycle.
- Latency: with start sampled high in IDLE at cycle 0, LOAD occupies cycle 1, and EXAM/SHIFT occupy cycles 2 … 2·WIDTH+1.
- done is high in cycle 2·WIDTH+2 only. The earliest next start is sampled in cycle 2·WIDTH+3 (IDLE).
- busy is high in cycles 1 … 2·WIDTH+2.
- multiplierReg is valid from cycle 2, since it was loaded at the end of LOAD.
- idx never exceeds WIDTH-1; there is no wrap-around.

## Test plan
All scenarios use WIDTH=4, with the controller driving a datapath instance.

- **Basic multiply:** multiplicand=3, multiplier=5, start pulse in IDLE → done in cycle 10. product=15, rsload asserted only for idx 0 and 2, exactly 4 rsshr pulses, done_t=0.
- **Extreme operands:** 15×15 → product=225, rsload asserted in all 4 EXAM cycles. Then 0×9 → product=0 with identical timing: done still in cycle 10, busy pattern unchanged.
- **Taint propagation:**
  - start_t=1, multiplier=6 → all strobe _t outputs follow their strobes' states, done_t=1.
  - Next run with start_t=0 and multiplierReg_t=1 → only rsload_t is high, in the 4 EXAM cycles; done_t=0.
- **Start ignored while busy:** assert start continuously through one run → no LOAD re-entry before done. A second run begins with LOAD in cycle 12 (IDLE in 11).
- **Reset mid-operation:** reset in cycle 5 → state is IDLE, all outputs 0 and ctl_t=0 from cycle 6. A fresh start then completes normally: 2×7=14.
- **Reset/start collision:** reset and start both high in the same IDLE cycle → stays IDLE, no mdld pulse.
